collision_detect: RTL and testbench

Per-frame hit detector that produces the `i_Collision` event consumed by the lives counter. It watches the pixel stream from the player and obstacle renderers and latches any overlap in the active area during a frame. At the next frame boundary it issues a single-cycle collision pulse, then opens a frame-counted invincibility window during which further overlaps are ignored. It also drives the player blink enable used by the sprite renderer.

---
 rtl/collision_detect.sv | 177 +++++++++++++++++
 tb/tb_collision_detect.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/collision_detect.sv
// collision_detect
//   Per-frame hit detector. It watches the player and obstacle pixel streams.
//   It latches any overlap in the visible area during a frame. At the next
//   frame boundary it emits a single-cycle registered collision pulse. It then
//   holds a frame-counted invincibility (grace) window in which further
//   overlaps are ignored. It also drives the player blink enable used by the
//   sprite renderer.
//
// Optional feature macro: COLLISION_BLINK_EN
//   defined   : a grace-frame blink counter drives o_Player_Visible.
//   undefined : o_Player_Visible is constant 1; grace timing is unchanged.
//
// Parameters
//   GRACE_FRAMES     frames of invincibility after a hit (1..255)
//   BLINK_SHIFT      blink toggles every 2^BLINK_SHIFT frames during grace
//
// Ports
//   i_Clk            pixel clock
//   i_Reset          asynchronous, active-high reset
//   i_Frame_Start    one-cycle pulse at the first cycle of each frame
//   i_Active         scan is in the visible area
//   i_Player_Px      player sprite covers the current pixel
//   i_Obstacle_Px    an obstacle covers the current pixel
//   i_Game_Over      level, lives count is zero
//   o_Collision      one-cycle registered hit pulse
//   o_Invincible     high in HIT and GRACE
//   o_Player_Visible player draw enable
//   o_Grace_Left     remaining grace frames
//
// state   | meaning
// --------+--------------------------------------------------------------
// ARMED   | waiting for a frame boundary with a latched overlap
// HIT     | single cycle; collision pulse out, grace counter loaded
// GRACE   | invincible; counts frame starts down to zero
// LOCKED  | game over; no pulses until reset

module collision_detect #(
   parameter int unsigned GRACE_FRAMES = 60,
   parameter int unsigned BLINK_SHIFT  = 3
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Frame_Start,
   input  logic       i_Active,
   input  logic       i_Player_Px,
   input  logic       i_Obstacle_Px,
   input  logic       i_Game_Over,
   output logic       o_Collision,
   output logic       o_Invincible,
   output logic       o_Player_Visible,
   output logic [7:0] o_Grace_Left
);

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      HIT    = 2'd1,
      GRACE  = 2'd2,
      LOCKED = 2'd3
   } state_t;

   localparam logic [7:0] GraceLoad = 8'(GRACE_FRAMES);

   state_t     state_q, state_d;
   logic       hit_seen_q, hit_seen_d;
   logic [7:0] grace_q, grace_d;
   logic       collision_q, collision_d;
   logic       overlap;

   assign overlap = i_Active & i_Player_Px & i_Obstacle_Px;

   // An overlap in the frame-start cycle belongs to the new frame, so it
   // wins over the clear. The boundary decision reads hit_seen_q, which is
   // the value from before the clear.
   always_comb begin
      hit_seen_d = hit_seen_q | overlap;
      if (i_Frame_Start) begin
         hit_seen_d = overlap;
      end
   end

   always_comb begin
      state_d = state_q;
      grace_d = grace_q;
      case (state_q)
         ARMED: begin
            grace_d = 8'd0;
            if (i_Game_Over) begin
               state_d = LOCKED;
            end else if (i_Frame_Start && hit_seen_q) begin
               state_d = HIT;
            end
         end
         HIT: begin
            if (i_Game_Over) begin
               state_d = LOCKED;
               grace_d = 8'd0;
            end else begin
               state_d = GRACE;
               grace_d = GraceLoad;
            end
         end
         GRACE: begin
            if (i_Game_Over) begin
               state_d = LOCKED;
               grace_d = 8'd0;
            end else if (i_Frame_Start) begin
               grace_d = grace_q - 8'd1;
               // The last decrement lands on 0 and re-arms in the same cycle.
               // The same frame start clears hit_seen, so an overlap seen
               // during grace is never charged.
               if (grace_q == 8'd1) begin
                  state_d = ARMED;
               end
            end
         end
         LOCKED: begin
            grace_d = 8'd0;
         end
         default: begin
            state_d = ARMED;
            grace_d = 8'd0;
         end
      endcase
   end

   // The pulse is registered alongside the state, so it is high exactly
   // while the state register holds HIT.
   assign collision_d = (state_d == HIT);

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q     <= ARMED;
         hit_seen_q  <= 1'b0;
         grace_q     <= 8'd0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hit_seen_q  <= hit_seen_d;
         grace_q     <= grace_d;
         collision_q <= collision_d;
      end
   end

   assign o_Collision  = collision_q;
   assign o_Invincible = (state_q == HIT) || (state_q == GRACE);
   assign o_Grace_Left = grace_q;

`ifdef COLLISION_BLINK_EN
   logic [BLINK_SHIFT:0] blink_q, blink_d;

   // The counter is held at zero outside GRACE. Entry into GRACE therefore
   // always starts from zero, with the player visible.
   always_comb begin
      blink_d = blink_q;
      if (state_q != GRACE) begin
         blink_d = '0;
      end else if (i_Frame_Start) begin
         blink_d = blink_q + (BLINK_SHIFT + 1)'(1);
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         blink_q <= '0;
      end else begin
         blink_q <= blink_d;
      end
   end

   assign o_Player_Visible = (state_q == GRACE) ? ~blink_q[BLINK_SHIFT] : 1'b1;
`else
   logic [BLINK_SHIFT:0] unused_blink;
   assign unused_blink     = '0;
   assign o_Player_Visible = 1'b1;
`endif

endmodule

// File: tb/tb_collision_detect.sv
module tb_collision_detect;

   logic       i_Clk = 1'b0;
   logic       i_Reset;
   logic       i_Frame_Start;
   logic       i_Active;
   logic       i_Player_Px;
   logic       i_Obstacle_Px;
   logic       i_Game_Over;
   logic       o_Collision;
   logic       o_Invincible;
   logic       o_Player_Visible;
   logic [7:0] o_Grace_Left;

   int n_pass  = 0;
   int n_total = 0;

   collision_detect #(
      .GRACE_FRAMES (4),
      .BLINK_SHIFT  (1)
   ) dut (
      .i_Clk            (i_Clk),
      .i_Reset          (i_Reset),
      .i_Frame_Start    (i_Frame_Start),
      .i_Active         (i_Active),
      .i_Player_Px      (i_Player_Px),
      .i_Obstacle_Px    (i_Obstacle_Px),
      .i_Game_Over      (i_Game_Over),
      .o_Collision      (o_Collision),
      .o_Invincible     (o_Invincible),
      .o_Player_Visible (o_Player_Visible),
      .o_Grace_Left     (o_Grace_Left)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Expected blink output during GRACE with BLINK_SHIFT=1 after cnt frames.
   function automatic int vis_exp(input int cnt);
`ifdef COLLISION_BLINK_EN
      return ((cnt >> 1) & 1) ? 0 : 1;
`else
      return 1;
`endif
   endfunction

   // One clock: inputs applied at the falling edge, outputs read at the next.
   task automatic step(input logic fs, input logic ov, input logic act = 1'b1);
      i_Frame_Start = fs;
      i_Active      = act;
      i_Player_Px   = ov;
      i_Obstacle_Px = ov;
      @(posedge i_Clk);
      @(negedge i_Clk);
      i_Frame_Start = 1'b0;
      i_Active      = 1'b0;
      i_Player_Px   = 1'b0;
      i_Obstacle_Px = 1'b0;
   endtask

   task automatic do_reset();
      i_Reset = 1'b1;
      @(negedge i_Clk);
      i_Reset = 1'b0;
   endtask

   initial begin
      i_Reset       = 1'b1;
      i_Frame_Start = 1'b0;
      i_Active      = 1'b0;
      i_Player_Px   = 1'b0;
      i_Obstacle_Px = 1'b0;
      i_Game_Over   = 1'b0;
      @(negedge i_Clk);
      chk("rst_col", o_Collision, 0);
      chk("rst_inv", o_Invincible, 0);
      chk("rst_vis", o_Player_Visible, 1);
      chk("rst_gl",  o_Grace_Left, 0);
      i_Reset = 1'b0;

      // Single hit with a grace countdown; one overlap in the last grace frame
      // must not be charged after re-arming.
      step(1, 0);
      step(0, 1);
      step(0, 0);
      chk("pre_col", o_Collision, 0);
      step(1, 0);
      chk("hit_col", o_Collision, 1);
      chk("hit_inv", o_Invincible, 1);
      step(0, 0);
      chk("hit_width", o_Collision, 0);
      chk("gr_gl0", o_Grace_Left, 4);
      chk("gr_inv0", o_Invincible, 1);
      chk("gr_vis0", o_Player_Visible, vis_exp(0));
      for (int k = 1; k <= 4; k++) begin
         step(0, (k == 4) ? 1'b1 : 1'b0);
         step(0, 0);
         step(1, 0);
         chk($sformatf("gr_gl%0d", k), o_Grace_Left, 4 - k);
         chk($sformatf("gr_col%0d", k), o_Collision, 0);
         chk($sformatf("gr_inv%0d", k), o_Invincible, (k < 4) ? 1 : 0);
         chk($sformatf("gr_vis%0d", k), o_Player_Visible, (k < 4) ? vis_exp(k) : 1);
      end
      step(0, 0);
      step(1, 0);
      chk("stale_col", o_Collision, 0);

      // Overlap in every frame: pulses at frame starts 1, 6, 11 only.
      for (int f = 0; f <= 13; f++) begin
         step(1, 0);
         chk($sformatf("mask_fs%0d", f), o_Collision, (f == 1 || f == 6 || f == 11) ? 1 : 0);
         step(0, 0);
         chk($sformatf("mask_nx%0d", f), o_Collision, 0);
         step(0, 1);
         step(0, 0);
      end
      chk("mask_gl", o_Grace_Left, 2);

      // Asynchronous reset while in grace.
      #2 i_Reset = 1'b1;
      #1;
      chk("arst_col", o_Collision, 0);
      chk("arst_inv", o_Invincible, 0);
      chk("arst_vis", o_Player_Visible, 1);
      chk("arst_gl",  o_Grace_Left, 0);
      @(negedge i_Clk);
      i_Reset = 1'b0;
      step(1, 0);
      chk("arst_fs", o_Collision, 0);
      step(0, 1);
      step(1, 0);
      chk("arst_hit", o_Collision, 1);

      // Overlap gating: inactive area and frame-start coincidence.
      do_reset();
      step(1, 0);
      step(0, 1, 1'b0);
      step(1, 0);
      chk("gate_inact", o_Collision, 0);
      step(1, 1);
      chk("gate_coinc0", o_Collision, 0);
      step(0, 0);
      step(1, 0);
      chk("gate_coinc1", o_Collision, 1);

      // Game over while a hit is pending.
      do_reset();
      step(1, 0);
      step(0, 1);
      i_Game_Over = 1'b1;
      step(0, 0);
      chk("go_inv", o_Invincible, 0);
      chk("go_gl",  o_Grace_Left, 0);
      chk("go_vis", o_Player_Visible, 1);
      step(1, 0);
      chk("go_col0", o_Collision, 0);
      step(0, 1);
      step(1, 0);
      chk("go_col1", o_Collision, 0);
      chk("go_vis1", o_Player_Visible, 1);
      i_Game_Over = 1'b0;
      step(0, 1);
      step(1, 0);
      chk("lock_col", o_Collision, 0);
      chk("lock_inv", o_Invincible, 0);

      // Game over during HIT: the pulse stands, LOCKED follows.
      do_reset();
      step(0, 1);
      step(1, 0);
      chk("gohit_col", o_Collision, 1);
      i_Game_Over = 1'b1;
      step(0, 0);
      chk("gohit_col2", o_Collision, 0);
      chk("gohit_inv", o_Invincible, 0);
      chk("gohit_gl",  o_Grace_Left, 0);
      i_Game_Over = 1'b0;
      step(0, 1);
      step(1, 0);
      chk("gohit_lock", o_Collision, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
